// File: rtl/bmc_seq.sv
// Time-shared branch-metric sequencer: one received pair -> 8 per-state metric beats for the ACS array.
// Latency: pair accepted at edge N gives the state-0 beat in the next cycle; one beat per accepted cycle.
// Backpressure: acs_ready=0 holds the beat stable; rx_ready only rises in IDLE or on an accepted last beat.
// Optional feature: define BMC_SEQ_ERASE_EN to add the rx_erase port and erasure masking.
module bmc_seq #(
  parameter logic [15:0] EXP_P0 = 16'h3C3C,
  parameter logic [15:0] EXP_P1 = 16'hC3C3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [1:0]  rx_pair,
`ifdef BMC_SEQ_ERASE_EN
  input  logic [1:0]  rx_erase,
`endif
  output logic        bm_valid,
  input  logic        acs_ready,
  output logic [2:0]  bm_state,
  output logic [1:0]  bm_path0,
  output logic [1:0]  bm_path1,
  output logic        bm_last,
  output logic        busy,
  output logic [15:0] sym_cnt
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;
  logic [1:0]  pair_q;
  logic [1:0]  erase_v;
  logic        capture;
  logic        accept;
  logic        at_last;

  // Hamming distance between received pair and expected pair; erased bits never contribute.
  function automatic logic [1:0] metric(input logic [1:0] p, input logic [1:0] e,
                                        input logic [1:0] er);
    logic a;
    logic b;
    a = (p[0] ^ e[0]) & ~er[0];
    b = (p[1] ^ e[1]) & ~er[1];
    return {a & b, a ^ b};
  endfunction

  assign at_last  = (state_q == SWEEP) && (idx_q == 3'd7);
  assign rx_ready = (state_q == IDLE) || (at_last && acs_ready);
  assign accept   = rx_valid && rx_ready;

  // FSM state register and sweep index / completed-sweep counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      sym_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  // Next-state: clr wins over everything; a last beat may chain straight into the next pair.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sym_cnt_d = sym_cnt_q;
    capture   = 1'b0;
    if (clr) begin
      state_d   = IDLE;
      idx_d     = 3'd0;
      sym_cnt_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SWEEP;
            idx_d   = 3'd0;
            capture = 1'b1;
          end
        end
        SWEEP: begin
          if (acs_ready) begin
            if (idx_q != 3'd7) begin
              idx_d = idx_q + 3'd1;
            end else begin
              sym_cnt_d = sym_cnt_q + 16'd1;
              idx_d     = 3'd0;
              if (accept) begin
                capture = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Received pair is held for the whole sweep; cleared by clr so stale data never leaks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_q <= 2'b00;
    end else if (clr) begin
      pair_q <= 2'b00;
    end else if (capture) begin
      pair_q <= rx_pair;
    end
  end

`ifdef BMC_SEQ_ERASE_EN
  logic [1:0] erase_q;

  // Erasure flags travel with the pair they were received with.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      erase_q <= 2'b00;
    end else if (clr) begin
      erase_q <= 2'b00;
    end else if (capture) begin
      erase_q <= rx_erase;
    end
  end

  assign erase_v = erase_q;
`else
  assign erase_v = 2'b00;
`endif

  assign bm_valid = (state_q == SWEEP);
  assign busy     = (state_q == SWEEP);
  assign bm_state = idx_q;
  assign bm_last  = at_last;
  assign sym_cnt  = sym_cnt_q;
  assign bm_path0 = metric(pair_q, EXP_P0[{idx_q, 1'b0} +: 2], erase_v);
  assign bm_path1 = metric(pair_q, EXP_P1[{idx_q, 1'b0} +: 2], erase_v);

endmodule
